trng_vn_sampler: RTL and testbench
==================================

// Module: trng_vn_sampler
// PURPOSE
//   Consumes the free-running ring-oscillator bit (ro_out of ring_osc) and turns it into
//   debiased, health-checked entropy bytes. Stages: 2-FF synchronizer, divided sample
//   strobe, von Neumann debiaser, repetition-count health test, byte packer.
//   The byte packer drives a single-entry valid/ready output register.
//   Sits between ring_osc and the uo_out/uio_out mux in the tt_um top.
// PARAMETERS
//   SAMPLE_DIV  4   clk cycles per raw sample (>=2); strobe on the last count
//   RCT_LIMIT   32  consecutive identical raw samples that trip health_fail (2..255)
// PORTS
//   clk          in   1  system clock; all logic on its rising edge
//   rst_n        in   1  asynchronous active-low reset
//   ro_in        in   1  raw ring-oscillator bit, asynchronous to clk
//   enable       in   1  1 = sample and produce bytes; 0 = flush pipeline
//   out_data     out  8  debiased entropy byte
//   out_valid    out  1  out_data holds an unconsumed byte
//   out_ready    in   1  consumer accepts out_data when out_valid & out_ready
//   health_fail  out  1  sticky repetition-count failure
//   overflow     out  1  sticky: a completed byte was dropped (output still full)
// BEHAVIOUR
//   Reset values (rst_n=0, async): out_data=0, out_valid=0, health_fail=0, overflow=0.
//   Reset also clears the sync FFs, div counter, FSM (IDLE), shift reg, bit count and RCT.
//   Sync: ro_sync = ro_in delayed by two flops; only ro_sync is used downstream.
//   Strobe: div counter runs 0..SAMPLE_DIV-1 while enable=1; strobe=1 when count==SAMPLE_DIV-1.
//     enable=0 holds the counter at 0. First strobe is SAMPLE_DIV cycles after enable rises.
//   FSM: IDLE -> PAIR_A when enable=1. PAIR_A: on strobe latch a=ro_sync, go PAIR_B.
//     PAIR_B: on strobe b=ro_sync. If a!=b, push a; 01->0, 10->1. 00/11 discarded.
//     Then go to PAIR_A. enable=0 in any state -> IDLE next cycle.
//   Packer: shift left, new bit into LSB; 3-bit count. 8th push completes a byte.
//     The first pushed bit lands in out_data[7].
//   Output: on completion, if out_valid=0 (or out_ready=1 in the same cycle),
//     out_data<=byte and out_valid<=1 next cycle. Latency: 1 clk after the completing strobe.
//     If out_valid=1 & out_ready=0 at completion, the byte is dropped, overflow<=1,
//     and out_data is unchanged.
//     Count/shift reg clear after completion either way.
//   Handshake: out_valid & out_ready clears out_valid next cycle unless a new byte loads
//     the same cycle. out_data is stable while out_valid=1 & out_ready=0.
//   RCT: on each strobe, run counter = (ro_sync==prev sample) ? run+1 : 1, saturating at
//     RCT_LIMIT. run==RCT_LIMIT sets health_fail the next cycle.
//     While health_fail=1: no pushes and no new bytes. A pending out_valid byte is still
//     deliverable.
//   health_fail and overflow clear only on rst_n=0 or an enable 1->0 transition.
//   enable=0 flush: partial bits, bit count, RCT run and FSM cleared.
//     A pending out_data/out_valid is kept until consumed.
//   Reset mid-byte: everything returns to reset values immediately (async), no byte is emitted.
// TESTING
//   T1 SAMPLE_DIV=4, pairs 10,01,10,10,01,01,10,01 -> out_valid=1, out_data=8'hB2,
//      1 clk after the 16th strobe.
//   T2 Same pairs as T1, with 00 and 11 inserted between each -> identical 8'hB2, same count
//      of emitted bytes (1).
//   T3 ro_in held 1, RCT_LIMIT=32 -> health_fail=1 one clk after the 32nd strobe,
//      out_valid stays 0; enable toggle 1->0->1 clears it.
//   T4 out_ready=0, generate two full bytes (8'hB2, then 8'h4D) -> out_data stays 8'hB2,
//      overflow=1; out_ready pulse -> out_valid drops next cycle.
//   T5 enable=0 after 5 debiased bits, then re-enable with 8 fresh pairs -> first byte
//      built only from fresh pairs.
//   T6 rst_n low mid-byte with out_valid=1 -> all outputs 0 asynchronously, no byte
//      appears after release until 8 new pairs.

Source files
------------

// File: rtl/trng_vn_sampler.sv
// Ring-oscillator entropy sampler: sync, divided strobe, von Neumann debias, RCT health test, byte packer.
// Latency: a byte is presented one clk after the strobe that completes it; health_fail one clk after the tripping strobe.
// Backpressure: single-entry output register; a byte completed while it is still full is dropped and flags overflow.
module trng_vn_sampler #(
    parameter int SAMPLE_DIV = 4,
    parameter int RCT_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ro_in,
    input  logic       enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       health_fail,
    output logic       overflow
);

    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RCT_LIMIT);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PAIR_A = 2'd1,
        ST_PAIR_B = 2'd2
    } state_t;

    logic             ro_meta;
    logic             ro_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             strobe;
    logic             enable_q;
    logic             enable_fall;

    state_t           state_q;
    state_t           state_d;
    logic             latch_a;
    logic             pair_done;
    logic             a_q;

    logic             push_vld;
    logic             push_bit;
    logic [6:0]       shift_q;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic [7:0]       byte_dat;
    logic             out_load;
    logic             out_drop;

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             prev_q;
    logic             rct_trip;

    // ro_in is asynchronous to clk; nothing downstream may look at it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_meta <= 1'b0;
            ro_sync <= 1'b0;
        end else begin
            ro_meta <= ro_in;
            ro_sync <= ro_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable || strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign strobe = enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
        end
    end

    assign enable_fall = enable_q && !enable;

    // Pairing FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pairing FSM: next state.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_PAIR_A;
                ST_PAIR_A: if (strobe) state_d = ST_PAIR_B;
                ST_PAIR_B: if (strobe) state_d = ST_PAIR_A;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Pairing FSM: outputs. Equal pairs carry bias and are discarded.
    always_comb begin
        latch_a   = 1'b0;
        pair_done = 1'b0;
        case (state_q)
            ST_PAIR_A: latch_a   = strobe;
            ST_PAIR_B: pair_done = strobe;
            default: ;
        endcase
    end

    assign push_vld = pair_done && (a_q != ro_sync) && !health_fail;
    assign push_bit = a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= 1'b0;
        end else if (latch_a) begin
            a_q <= ro_sync;
        end
    end

    assign byte_done = push_vld && (bit_cnt == 3'd7);
    assign byte_dat  = {shift_q, push_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (!enable || byte_done) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (push_vld) begin
            shift_q <= {shift_q[5:0], push_bit};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // A slot freed by a same-cycle handshake can take the new byte.
    assign out_load = byte_done && (!out_valid || out_ready);
    assign out_drop = byte_done && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_data  <= byte_dat;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (enable_fall) begin
            overflow <= 1'b0;
        end else if (out_drop) begin
            overflow <= 1'b1;
        end
    end

    // Run length of identical raw samples; zero means no previous sample this session.
    always_comb begin
        run_d = run_q;
        if (!enable) begin
            run_d = '0;
        end else if (strobe) begin
            if ((run_q != '0) && (ro_sync == prev_q)) begin
                run_d = (run_q == RUN_LIMIT) ? run_q : run_q + RUN_W'(1);
            end else begin
                run_d = RUN_ONE;
            end
        end
    end

    assign rct_trip = strobe && (run_d == RUN_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            run_q <= run_d;
            if (strobe) begin
                prev_q <= ro_sync;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            health_fail <= 1'b0;
        end else if (enable_fall) begin
            health_fail <= 1'b0;
        end else if (rct_trip) begin
            health_fail <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trng_vn_sampler.sv
// Bench for trng_vn_sampler: directed scenarios plus randomized sample streams
// checked against a sample-list reference model.
module tb_trng_vn_sampler;

    localparam int DIV = 4;
    localparam int RCT = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ro_in;
    logic       enable;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       health_fail;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    bit         smp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    bit         exp_hf;

    trng_vn_sampler #(
        .SAMPLE_DIV (DIV),
        .RCT_LIMIT  (RCT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ro_in       (ro_in),
        .enable      (enable),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // One clock; every accepted byte is visible for exactly one of these windows.
    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid && out_ready) cap_q.push_back(out_data);
    endtask

    // One raw sample window: ro_in held for a full strobe period.
    task automatic sample(input bit b);
        ro_in = b;
        smp_q.push_back(b);
        repeat (DIV) tick();
    endtask

    task automatic send_bit(input bit b);
        sample(b);
        sample(!b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic start();
        smp_q.delete();
        cap_q.delete();
        enable = 1'b1;
    endtask

    task automatic stop();
        enable = 1'b0;
        tick();
        tick();
    endtask

    // Reference: pair raw samples, debias, run-length health test, group into bytes MSB first.
    task automatic build_expected();
        int         run;
        int         nb;
        bit         a;
        bit         prev;
        logic [7:0] acc;
        exp_q.delete();
        run = 0; nb = 0; a = 0; prev = 0; acc = 8'h00; exp_hf = 0;
        for (int j = 0; j < smp_q.size(); j++) begin
            bit s;
            s = smp_q[j];
            if (j % 2 == 0) begin
                a = s;
            end else if (!exp_hf && (a != s)) begin
                acc = {acc[6:0], a};
                nb++;
                if (nb == 8) begin
                    exp_q.push_back(acc);
                    nb = 0;
                    acc = 8'h00;
                end
            end
            if (run != 0 && s == prev) run = (run < RCT) ? run + 1 : run;
            else run = 1;
            prev = s;
            if (run == RCT) exp_hf = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; ro_in = 1'b0;
        #3;
        checks++;
        if ({out_data, out_valid, health_fail, overflow} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h vld=%b hf=%b ovf=%b expected all 0",
                     out_data, out_valid, health_fail, overflow);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_data, out_valid, health_fail, overflow} !== 11'h000) begin
            errors++;
            $display("FAIL reset_release_idle: got data=%h vld=%b hf=%b ovf=%b expected all 0",
                     out_data, out_valid, health_fail, overflow);
        end
    endtask

    task automatic test_basic_byte();
        logic [7:0] v;
        v = 8'hB2;
        out_ready = 1'b0;
        start();
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        sample(1'b0);
        ro_in = 1'b1;
        repeat (DIV - 1) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_early_valid: got out_valid=%b expected 0 before 16th strobe", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hB2) begin
            errors++;
            $display("FAIL t1_byte: got vld=%b data=%h expected vld=1 data=b2", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_handshake: got out_valid=%b expected 0", out_valid);
        end
        stop();
    endtask

    task automatic test_discard_pairs();
        logic [7:0] v;
        v = 8'hB2;
        out_ready = 1'b1;
        start();
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (i > 0) begin
                sample(i[0]);
                sample(i[0]);
            end
        end
        stop();
        repeat (4) tick();
        checks++;
        if (cap_q.size() != 1) begin
            errors++;
            $display("FAIL t2_count: got %0d bytes expected 1", cap_q.size());
        end else begin
            checks++;
            if (cap_q[0] !== 8'hB2) begin
                errors++;
                $display("FAIL t2_data: got %h expected b2", cap_q[0]);
            end
        end
    endtask

    task automatic test_health();
        out_ready = 1'b1;
        start();
        repeat (RCT - 1) sample(1'b1);
        checks++;
        if (health_fail !== 1'b0) begin
            errors++;
            $display("FAIL t3_early_hf: got health_fail=%b expected 0 after %0d strobes", health_fail, RCT - 1);
        end
        sample(1'b1);
        checks++;
        if (health_fail !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t3_trip: got hf=%b vld=%b expected hf=1 vld=0", health_fail, out_valid);
        end
        send_byte(8'hB2);
        checks++;
        if (cap_q.size() != 0 || health_fail !== 1'b1) begin
            errors++;
            $display("FAIL t3_blocked: got %0d bytes hf=%b expected 0 bytes hf=1", cap_q.size(), health_fail);
        end
        stop();
        checks++;
        if (health_fail !== 1'b0) begin
            errors++;
            $display("FAIL t3_clear: got health_fail=%b expected 0 after enable toggle", health_fail);
        end
        start();
        send_byte(8'h4D);
        tick();
        checks++;
        if (cap_q.size() != 1 || cap_q[0] !== 8'h4D) begin
            errors++;
            $display("FAIL t3_recover: got %0d bytes first=%h expected 1 byte 4d",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'hxx);
        end
        stop();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        start();
        send_byte(8'hB2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hB2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL t4_first: got vld=%b data=%h ovf=%b expected 1 b2 0", out_valid, out_data, overflow);
        end
        send_byte(8'h4D);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hB2 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL t4_drop: got vld=%b data=%h ovf=%b expected 1 b2 1", out_valid, out_data, overflow);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL t4_drain: got vld=%b ovf=%b expected vld=0 ovf=1", out_valid, overflow);
        end
        stop();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL t4_ovf_clear: got overflow=%b expected 0", overflow);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        start();
        repeat (5) send_bit(1'b1);
        stop();
        repeat (3) tick();
        start();
        send_byte(8'h4D);
        stop();
        checks++;
        if (cap_q.size() != 1 || cap_q[0] !== 8'h4D) begin
            errors++;
            $display("FAIL t5_fresh: got %0d bytes first=%h expected 1 byte 4d",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        out_ready = 1'b0;
        start();
        send_byte(8'hB2);
        send_byte(8'h4D);
        for (int i = 7; i >= 5; i--) send_bit(v[i]);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_data, out_valid, health_fail, overflow} !== 11'h000) begin
            errors++;
            $display("FAIL t6_async_reset: got data=%h vld=%b hf=%b ovf=%b expected all 0",
                     out_data, out_valid, health_fail, overflow);
        end
        enable = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start();
        for (int i = 7; i >= 3; i--) send_bit(v[i]);
        checks++;
        if (cap_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_no_early_byte: got %0d bytes vld=%b expected none", cap_q.size(), out_valid);
        end
        for (int i = 2; i >= 0; i--) send_bit(v[i]);
        tick();
        checks++;
        if (cap_q.size() != 1 || cap_q[0] !== v) begin
            errors++;
            $display("FAIL t6_fresh_byte: got %0d bytes first=%h expected 1 byte %h",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'hxx, v);
        end
        stop();
    endtask

    // mode 0: independent random bits; mode 1: random run lengths, occasionally long enough to trip RCT.
    task automatic test_random(input int mode);
        bit val;
        int len;
        out_ready = 1'b1;
        start();
        val = 1'($urandom_range(0, 1));
        while (smp_q.size() < 240) begin
            if (mode == 0) begin
                sample(1'($urandom_range(0, 1)));
            end else begin
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(RCT - 2, RCT + 4) : $urandom_range(1, 4);
                repeat (len) sample(val);
                val = !val;
            end
        end
        build_expected();
        checks++;
        if (health_fail !== exp_hf) begin
            errors++;
            $display("FAIL rand%0d_hf: got health_fail=%b expected %b", mode, health_fail, exp_hf);
        end
        stop();
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d bytes expected %0d", mode, cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d: got %h expected %h", mode, i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_discard_pairs();
        test_health();
        test_overflow();
        test_flush();
        test_reset_mid_byte();
        test_random(0);
        test_random(1);
        test_random(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
